sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param.sv | 114 +++++++++++
 tb/tb_sync_fifo_param.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, one-cycle overflow/underflow pulses and selectable FWFT read mode.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow,
  output logic [AW:0]      fifo_cnt
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("sync_fifo_param: AE_LEVEL must be below AF_LEVEL");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_LEVEL must not exceed DEPTH");
  end

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_CNT    = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT    = (AW + 1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rd_ok, wr_ok;

  // Flags decode the registered count so they move in the same cycle as it.
  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == DEPTH_CNT);
  assign almost_empty = (cnt_q <= AE_CNT);
  assign almost_full  = (cnt_q >= AF_CNT);
  assign fifo_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A read frees a slot this edge, so a write to a full FIFO is still taken.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + (AW + 1)'(wr_ok) - (AW + 1)'(rd_ok);
    ovf_d    = wr & ~wr_ok;
    unf_d    = rd & empty;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  // NOTE: state flops use non-blocking assignments; always_comb above uses blocking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are never observable
  // before being written, and leaving it unreset keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = mem_q[rd_ptr_q];
  end else begin : g_std
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (rd_ok) dout_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-read instance and an FWFT
// instance share clock and reset; expected values are hand-derived constants.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       wr, rd;
  logic [7:0] data_in, data_out;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] fifo_cnt;

  logic       wr_f, rd_f;
  logic [7:0] din_f, dout_f;
  logic       empty_f, full_f, ae_f, af_f, ovf_f, unf_f;
  logic [4:0] cnt_f;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow), .fifo_cnt(fifo_cnt)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1)) dut_fw (
    .clk(clk), .rst_n(rst_n), .wr(wr_f), .data_in(din_f), .rd(rd_f),
    .data_out(dout_f), .empty(empty_f), .full(full_f),
    .almost_empty(ae_f), .almost_full(af_f),
    .overflow(ovf_f), .underflow(unf_f), .fifo_cnt(cnt_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request lines; returns #1 after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    wr = w; rd = r; data_in = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic cyc_f(input logic w, input logic r, input logic [7:0] d);
    wr_f = w; rd_f = r; din_f = d;
    @(posedge clk); #1;
    wr_f = 1'b0; rd_f = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wr = 0; rd = 0; data_in = '0; wr_f = 0; rd_f = 0; din_f = '0;

    // Reset / idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_cnt", fifo_cnt, 0);
    check("rst_dout", data_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_empty", empty, 1);

    // Mid-burst asynchronous reset: 5 writes, one read so data_out is nonzero
    for (int i = 1; i <= 5; i++) cyc(1, 0, 8'(i));
    cyc(0, 1, 8'h00);
    check("pre_rst_dout", data_out, 8'h01);
    check("pre_rst_cnt", fifo_cnt, 4);
    #3 rst_n = 1'b0;
    #1;
    check("async_cnt", fifo_cnt, 0);
    check("async_empty", empty, 1);
    check("async_ae", almost_empty, 1);
    check("async_full", full, 0);
    check("async_dout", data_out, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill 1..16, then a rejected 17th write
    for (int i = 1; i <= 16; i++) begin
      cyc(1, 0, 8'(i));
      check("fill_cnt", fifo_cnt, i);
      check("fill_af", almost_full, (i >= 14));
      check("fill_ae", almost_empty, (i <= 2));
      check("fill_full", full, (i == 16));
    end
    cyc(1, 0, 8'hAA);
    check("ovf_pulse", overflow, 1);
    check("ovf_cnt", fifo_cnt, 16);
    cyc(0, 0, 8'h00);
    check("ovf_clear", overflow, 0);

    // Drain 16, then a rejected read
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 8'h00);
      check("drain_data", data_out, i);
      check("drain_cnt", fifo_cnt, 16 - i);
      check("drain_ae", almost_empty, (16 - i <= 2));
      check("drain_empty", empty, (i == 16));
    end
    cyc(0, 1, 8'h00);
    check("unf_pulse", underflow, 1);
    check("unf_hold", data_out, 16);
    check("unf_cnt", fifo_cnt, 0);
    cyc(0, 0, 8'h00);
    check("unf_clear", underflow, 0);

    // Empty with wr = rd = 1: only the write is taken
    cyc(1, 1, 8'h33);
    check("empty_rw_cnt", fifo_cnt, 1);
    check("empty_rw_unf", underflow, 1);
    check("empty_rw_dout", data_out, 16);
    cyc(0, 1, 8'h00);
    check("empty_rw_read", data_out, 8'h33);
    check("empty_rw_cnt0", fifo_cnt, 0);

    // Full with wr = rd = 1: both taken, 0x55 comes out last
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h80 + i));
    check("refill_full", full, 1);
    cyc(1, 1, 8'h55);
    check("full_rw_cnt", fifo_cnt, 16);
    check("full_rw_ovf", overflow, 0);
    check("full_rw_dout", data_out, 8'h80);
    for (int i = 1; i < 16; i++) begin
      cyc(0, 1, 8'h00);
      check("full_rw_seq", data_out, 8'(8'h80 + i));
    end
    cyc(0, 1, 8'h00);
    check("full_rw_last", data_out, 8'h55);
    check("full_rw_empty", empty, 1);

    // Wrap-around: 40 mixed operations, occupancy held within 3..9
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 8'(8'hC0 + i));
      sb.push_back(8'(8'hC0 + i));
    end
    for (int i = 0; i < 40; i++) begin
      int sel;
      logic do_wr, do_rd;
      logic [7:0] d, exp_d;
      sel = (i * 3) % 4;
      do_wr = (sel != 1);
      do_rd = (sel == 1) || (sel == 2);
      if (do_wr && !do_rd && sb.size() >= 9) begin do_wr = 0; do_rd = 1; end
      if (do_rd && !do_wr && sb.size() <= 3) begin do_wr = 1; do_rd = 0; end
      d = 8'(8'h40 + i);
      cyc(do_wr, do_rd, d);
      if (do_rd) begin
        exp_d = sb.pop_front();
        check("wrap_data", data_out, exp_d);
      end
      if (do_wr) sb.push_back(d);
      check("wrap_cnt", fifo_cnt, sb.size());
    end

    // FWFT instance
    cyc_f(1, 0, 8'h11);
    check("fwft_head", dout_f, 8'h11);
    check("fwft_nempty", empty_f, 0);
    cyc_f(1, 0, 8'h22);
    check("fwft_hold", dout_f, 8'h11);
    check("fwft_cnt2", cnt_f, 2);
    cyc_f(0, 1, 8'h00);
    check("fwft_second", dout_f, 8'h22);
    cyc_f(0, 1, 8'h00);
    check("fwft_empty", empty_f, 1);
    cyc_f(1, 0, 8'h44);
    cyc_f(1, 1, 8'h66);
    check("fwft_rw_head", dout_f, 8'h66);
    check("fwft_rw_cnt", cnt_f, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
